// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer driving the seven-segment display bus.
// Loads a BCD start value, decrements once per prescaled second, and supports pause and cancel.
module countdown_timer #(
  parameter int TICK_DIV = 100_000_000,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cancel,
  input  logic       pause,
  input  logic [7:0] load_bcd,
  output logic [8:0] seconds,
  output logic       busy,
  output logic       expired,
  output logic       load_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] PRE_ONE = CNT_W'(1);

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] pre_reg, pre_next;
  logic [8:0]       seconds_reg, seconds_next;
  logic             busy_reg, busy_next;
  logic             expired_reg, expired_next;
  logic             load_err_reg, load_err_next;

  logic             load_ok;
  logic             counting;
  logic             tick;
  logic [3:0]       tens, ones;

  assign load_ok  = (load_bcd[7:4] <= 4'd9) && (load_bcd[3:0] <= 4'd9) && (load_bcd != 8'h00);
  assign counting = (state_reg == ST_RUN) && !pause;
  assign tick     = counting && (pre_reg == PRE_MAX);
  assign tens     = seconds_reg[7:4];
  assign ones     = seconds_reg[3:0];

  always_comb begin
    state_next    = state_reg;
    pre_next      = pre_reg;
    seconds_next  = seconds_reg;
    expired_next  = 1'b0;
    load_err_next = 1'b0;

    if (cancel) begin
      state_next   = ST_IDLE;
      seconds_next = 9'h000;
      pre_next     = '0;
    end else if (start && load_ok) begin
      state_next   = ST_RUN;
      seconds_next = {1'b1, load_bcd};
      pre_next     = '0;
    end else begin
      // A rejected start only flags the error; the running count is left alone.
      load_err_next = start;
      if (tick) begin
        pre_next = '0;
        if (seconds_reg[7:0] == 8'h01) begin
          state_next   = ST_IDLE;
          seconds_next = 9'h000;
          expired_next = 1'b1;
        end else if (ones != 4'd0) begin
          seconds_next = {1'b1, tens, ones - 4'd1};
        end else begin
          seconds_next = {1'b1, tens - 4'd1, 4'd9};
        end
      end else if (counting) begin
        pre_next = pre_reg + PRE_ONE;
      end
    end

    busy_next = (state_next == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      pre_reg      <= '0;
      seconds_reg  <= 9'h000;
      busy_reg     <= 1'b0;
      expired_reg  <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pre_reg      <= pre_next;
      seconds_reg  <= seconds_next;
      busy_reg     <= busy_next;
      expired_reg  <= expired_next;
      load_err_reg <= load_err_next;
    end
  end

  assign seconds  = seconds_reg;
  assign busy     = busy_reg;
  assign expired  = expired_reg;
  assign load_err = load_err_reg;

endmodule
